// File: rtl/core_id_ibuf_hzd.sv
// core_id_ibuf_hzd: decode-stage instruction queue with multi-producer RAW hazard hold
module core_id_ibuf_hzd #(
  parameter int PC_W    = 32,
  parameter int INST_W  = 32,
  parameter int RFIDX_W = 5,
  parameter int DEPTH   = 2,
  parameter int NPROD   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [PC_W-1:0]          i_pc,
  input  logic [INST_W-1:0]        i_inst,
  input  logic                     i_branch_predict,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [PC_W-1:0]          o_pc,
  output logic [INST_W-1:0]        o_inst,
  output logic                     o_branch_predict,
  output logic [RFIDX_W-1:0]       o_rs1_idx,
  output logic [RFIDX_W-1:0]       o_rs2_idx,
  input  logic                     i_rs1_ren,
  input  logic                     i_rs2_ren,
  input  logic [NPROD*RFIDX_W-1:0] prod_rd_idx,
  input  logic [NPROD-1:0]         prod_rd_wen,
  input  logic [NPROD-1:0]         prod_busy,
  input  logic                     i_pipe_flush_req,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                     o_raw_stall,
  output logic [CNT_W-1:0]         o_stall_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  bp_q;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [NPROD-1:0]  hz;
  logic              push, pop;

  for (genvar k = 0; k < NPROD; k++) begin : g_hz
    logic [RFIDX_W-1:0] idx;
    assign idx   = prod_rd_idx[k*RFIDX_W +: RFIDX_W];
    assign hz[k] = prod_rd_wen[k] & prod_busy[k] & (idx != '0) &
                   ((i_rs1_ren & (idx == o_rs1_idx)) | (i_rs2_ren & (idx == o_rs2_idx)));
  end

  assign o_count          = count;
  assign ready_in         = ~rst & (count != CW'(DEPTH));
  assign push             = valid_in & ready_in & ~i_pipe_flush_req;
  assign o_raw_stall      = (count != '0) & (|hz);
  assign valid_out        = (count != '0) & ~o_raw_stall & ~i_pipe_flush_req;
  assign pop              = valid_out & ready_out;
  assign o_pc             = pc_q[rd_ptr];
  assign o_inst           = inst_q[rd_ptr];
  assign o_branch_predict = bp_q[rd_ptr];
  assign o_rs1_idx        = o_inst[19:15];
  assign o_rs2_idx        = o_inst[24:20];

  // queue storage, pointers, occupancy and saturating stall counter; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_stall_cnt <= '0;
      bp_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      if (o_raw_stall & ~i_pipe_flush_req & ~&o_stall_cnt) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (i_pipe_flush_req) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          pc_q[wr_ptr]   <= i_pc;
          inst_q[wr_ptr] <= i_inst;
          bp_q[wr_ptr]   <= i_branch_predict;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: doc/core_id_ibuf_hzd.md
Name: core_id_ibuf_hzd

Overview:
- Parametrised decode-stage front end for the student core: a DEPTH-entry instruction queue between IF and decode.
- Instructions are held at the head until every source operand is free of hazards against NPROD producer stages (EX, MEM, ...). Each producer flags whether its result can be forwarded yet.
- Generalises the single-register ID stage: adds multi-entry buffering, an N-producer scoreboard check, queue-wide flush and a saturating stall counter.
- The external decoder sits on o_inst and returns source-read enables combinationally.

Parameters:
PC_W, 32, PC width
INST_W, 32, instruction width
RFIDX_W, 5, register index width
DEPTH, 2, queue entries; power of two, >=2
NPROD, 2, number of producer stages checked for RAW
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_in  in  1  IF entry valid
ready_in  out  1  queue can accept
i_pc  in  PC_W  IF pc
i_inst  in  INST_W  IF instruction
i_branch_predict  in  1  IF predicted-taken
valid_out  out  1  head issuable to EX
ready_out  in  1  EX accepts
o_pc  out  PC_W  head pc
o_inst  out  INST_W  head instruction
o_branch_predict  out  1  head prediction
o_rs1_idx  out  RFIDX_W  o_inst[19:15]
o_rs2_idx  out  RFIDX_W  o_inst[24:20]
i_rs1_ren  in  1  decoder: head reads rs1
i_rs2_ren  in  1  decoder: head reads rs2
prod_rd_idx  in  NPROD*RFIDX_W  producer k dest idx, slice k
prod_rd_wen  in  NPROD  producer k writes rd
prod_busy  in  NPROD  producer k result not forwardable this cycle
i_pipe_flush_req  in  1  discard all queued entries
o_count  out  $clog2(DEPTH+1)  occupancy
o_raw_stall  out  1  head blocked by hazard
o_stall_cnt  out  CNT_W  saturating hazard-stall cycle count

Behaviour:
- Storage: circular array with wr_ptr/rd_ptr of $clog2(DEPTH) bits; pointers wrap DEPTH-1 -> 0. Registered count, 0..DEPTH.
- ready_in = ~rst & (count != DEPTH). Registered state only; no combinational path from ready_out.
- push = valid_in & ready_in & ~i_pipe_flush_req. The entry is written at wr_ptr on the clock edge.
- Hazard per producer k: hz_k = prod_rd_wen[k] & prod_busy[k] & (prod_rd_idx_k != 0) & ((i_rs1_ren & prod_rd_idx_k == o_rs1_idx) | (i_rs2_ren & prod_rd_idx_k == o_rs2_idx)).
- o_raw_stall = (count != 0) & OR(hz_k).
- valid_out = (count != 0) & ~o_raw_stall & ~i_pipe_flush_req.
- pop = valid_out & ready_out; rd_ptr advances on pop.
- Head outputs (o_pc, o_inst, o_branch_predict) always show the entry at rd_ptr; they are stable while valid_out & ~ready_out.
- Latency: an entry pushed in cycle N can be valid_out in cycle N+1 at the earliest. There is no fall-through.
- Count update:
  - push & ~pop: +1
  - pop & ~push: -1
  - push & pop: unchanged (legal only when count in 1..DEPTH-1)
- Full and push-with-pop never coincide: ready_in=0 when full.
- Flush has priority over everything:
  - next cycle count=0 and wr_ptr=rd_ptr=0
  - the same-cycle input is discarded and nothing pops
  - valid_out=0 during the flush cycle
  - o_stall_cnt is unaffected
- Hazard clears once the producer drops prod_busy or advances. valid_out may rise in the same cycle, combinationally from prod_*.
- o_stall_cnt increments each cycle with o_raw_stall & ~i_pipe_flush_req, saturates at all-ones, and is cleared only by reset.
- Reset (synchronous): count=0, pointers=0, storage=0, o_stall_cnt=0.
  - Consequently valid_out=0, o_raw_stall=0, o_pc=0, o_inst=0, o_branch_predict=0.
  - ready_in=0 while rst is high and 1 in the first cycle after.
  - Reset mid-operation drops all entries with no output handshake.
- Empty queue: o_raw_stall=0 and no counting, regardless of prod_*.
- x0 destinations never cause a hazard.

Test Plan:
- Fill/drain, DEPTH=2, ready_out=0: push pc 0x100 then 0x104 -> ready_in=0, o_count=2. Raise ready_out -> pops 0x100 then 0x104 in order, o_count 2->1->0.
- Wrap-around, DEPTH=4: 10 back-to-back pushes (pc 0x0..0x24) with ready_out=1 -> identical order out, one per cycle after first-cycle latency, o_count stays at 1.
- Hazard: head inst 0x00208033 (add x0,x1,x2) with rs1_ren=1, prod1 idx=1, wen=1, busy=1 for 3 cycles.
  -> valid_out=0 and o_raw_stall=1 for 3 cycles, o_stall_cnt=3; issue in the cycle busy drops.
  -> Same with prod idx=0 -> no stall.
- Flush with count=2 and a simultaneous push -> next cycle o_count=0, valid_out=0, pushed entry absent; next push appears normally.
- Saturation, CNT_W=4: hold a hazard for 20 cycles -> o_stall_cnt reaches 15 and stays. Reset -> 0.
- Reset mid-stream with count=1 -> valid_out=0 during and after reset, o_pc=0, ready_in=0 while rst=1 and 1 the cycle after.
